// File: rtl/route_selector_adaptive.sv
// Per-input output-port selector for a 5-port mesh router: XY, YX or west-first adaptive
// routing, with a one-hot wormhole lock that is held until the tail flit transfers.
module route_selector_adaptive #(
  parameter int MAX_ROUTERS_X       = 4,
  parameter int MAX_ROUTERS_X_WIDTH = $clog2(MAX_ROUTERS_X),
  parameter int MAX_ROUTERS_Y       = 4,
  parameter int MAX_ROUTERS_Y_WIDTH = $clog2(MAX_ROUTERS_Y),
  parameter int ROUTER_X            = 0,
  parameter int ROUTER_Y            = 0,
  parameter int CHANNEL_NUMBER      = 5,
  parameter int ALGORITHM           = 0
) (
  input  logic                           clk_i,
  input  logic                           rst_n_i,
  input  logic                           head_valid_i,
  input  logic [MAX_ROUTERS_X_WIDTH-1:0] target_x_i,
  input  logic [MAX_ROUTERS_Y_WIDTH-1:0] target_y_i,
  output logic                           route_ready_o,
  input  logic [CHANNEL_NUMBER-1:0]      out_free_i,
  input  logic                           flit_fire_i,
  input  logic                           tail_i,
  output logic [CHANNEL_NUMBER-1:0]      selector_o,
  output logic                           route_valid_o,
  output logic                           route_error_o
);
  localparam int XW = MAX_ROUTERS_X_WIDTH;
  localparam int YW = MAX_ROUTERS_Y_WIDTH;
  localparam logic [XW:0]   X_LIMIT = MAX_ROUTERS_X[XW:0];
  localparam logic [YW:0]   Y_LIMIT = MAX_ROUTERS_Y[YW:0];
  localparam logic [XW-1:0] RX      = ROUTER_X[XW-1:0];
  localparam logic [YW-1:0] RY      = ROUTER_Y[YW-1:0];

  localparam int P_LOCAL = 0;
  localparam int P_NORTH = 1;
  localparam int P_EAST  = 2;
  localparam int P_SOUTH = 3;
  localparam int P_WEST  = 4;

  typedef enum logic [1:0] {IDLE, WAIT, LOCKED} state_t;

  state_t                      state_q, state_d;
  logic [CHANNEL_NUMBER-1:0]   sel_q, sel_d;
  logic                        vld_q, vld_d;
  logic                        err_q, err_d;
  logic                        rr_q, rr_d;
  logic [XW-1:0]               tx_q, tx_d;
  logic [YW-1:0]               ty_q, ty_d;

  logic [XW-1:0]               cur_x;
  logic [YW-1:0]               cur_y;
  logic                        out_of_range;
  logic [CHANNEL_NUMBER-1:0]   cand, grant, x_part, y_part, pick;
  logic                        tie;

  // Legal output directions for a target; local only when both coordinates match.
  function automatic logic [CHANNEL_NUMBER-1:0] candidates(input logic [XW-1:0] tx,
                                                            input logic [YW-1:0] ty);
    logic [CHANNEL_NUMBER-1:0] c;
    c = '0;
    if (ALGORITHM == 1) begin
      if (ty < RY)      c[P_NORTH] = 1'b1;
      else if (ty > RY) c[P_SOUTH] = 1'b1;
      else if (tx > RX) c[P_EAST]  = 1'b1;
      else if (tx < RX) c[P_WEST]  = 1'b1;
      else              c[P_LOCAL] = 1'b1;
    end else if (ALGORITHM == 2) begin
      if (tx < RX) c[P_WEST] = 1'b1;
      else begin
        if (tx > RX) c[P_EAST]  = 1'b1;
        if (ty < RY) c[P_NORTH] = 1'b1;
        if (ty > RY) c[P_SOUTH] = 1'b1;
        if (tx == RX && ty == RY) c[P_LOCAL] = 1'b1;
      end
    end else begin
      if (tx > RX)      c[P_EAST]  = 1'b1;
      else if (tx < RX) c[P_WEST]  = 1'b1;
      else if (ty < RY) c[P_NORTH] = 1'b1;
      else if (ty > RY) c[P_SOUTH] = 1'b1;
      else              c[P_LOCAL] = 1'b1;
    end
    return c;
  endfunction

  assign route_ready_o = (state_q == IDLE);
  assign selector_o    = sel_q;
  assign route_valid_o = vld_q;
  assign route_error_o = err_q;

  // In IDLE the route is evaluated on the incoming head; in WAIT on the stored target.
  always_comb begin
    cur_x = tx_q;
    cur_y = ty_q;
    if (state_q == IDLE) begin
      cur_x = target_x_i;
      cur_y = target_y_i;
    end
    out_of_range = ({1'b0, target_x_i} >= X_LIMIT) || ({1'b0, target_y_i} >= Y_LIMIT);
    cand   = candidates(cur_x, cur_y);
    grant  = cand & out_free_i;
    x_part = '0;
    y_part = '0;
    x_part[P_EAST]  = grant[P_EAST];
    x_part[P_WEST]  = grant[P_WEST];
    y_part[P_NORTH] = grant[P_NORTH];
    y_part[P_SOUTH] = grant[P_SOUTH];
    tie  = (ALGORITHM == 2) && (x_part != '0) && (y_part != '0);
    pick = grant;
    if (tie) pick = rr_q ? y_part : x_part;
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    vld_d   = vld_q;
    err_d   = 1'b0;
    rr_d    = rr_q;
    tx_d    = tx_q;
    ty_d    = ty_q;
    case (state_q)
      IDLE: begin
        if (head_valid_i) begin
          if (out_of_range) begin
            err_d = 1'b1;
          end else begin
            tx_d = target_x_i;
            ty_d = target_y_i;
            if (grant != '0) begin
              state_d = LOCKED;
              sel_d   = pick;
              vld_d   = 1'b1;
              if (tie) rr_d = ~rr_q;
            end else begin
              state_d = WAIT;
            end
          end
        end
      end
      WAIT: begin
        if (grant != '0) begin
          state_d = LOCKED;
          sel_d   = pick;
          vld_d   = 1'b1;
          if (tie) rr_d = ~rr_q;
        end
      end
      LOCKED: begin
        if (flit_fire_i && tail_i) begin
          state_d = IDLE;
          sel_d   = '0;
          vld_d   = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        sel_d   = '0;
        vld_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      sel_q   <= '0;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
      rr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      vld_q   <= vld_d;
      err_q   <= err_d;
      rr_q    <= rr_d;
    end
  end

  // Stored target is pure data and needs no reset.
  always_ff @(posedge clk_i) begin
    tx_q <= tx_d;
    ty_q <= ty_d;
  end
endmodule

// File: tb/tb_route_selector_adaptive.sv
// Bench for route_selector_adaptive: four instances (XY, YX, west-first, small mesh) share stimulus.
module tb_route_selector_adaptive;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       head_valid;
  logic [1:0] tx, ty;
  logic [4:0] out_free;
  logic       fire, tail;

  logic [4:0] sel_o [4];
  logic       vld_o [4];
  logic       rdy_o [4];
  logic       err_o [4];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  route_selector_adaptive #(.ROUTER_X(1), .ROUTER_Y(1), .ALGORITHM(0)) u_xy (
    .clk_i(clk), .rst_n_i(rst_n), .head_valid_i(head_valid), .target_x_i(tx), .target_y_i(ty),
    .route_ready_o(rdy_o[0]), .out_free_i(out_free), .flit_fire_i(fire), .tail_i(tail),
    .selector_o(sel_o[0]), .route_valid_o(vld_o[0]), .route_error_o(err_o[0]));

  route_selector_adaptive #(.ROUTER_X(1), .ROUTER_Y(1), .ALGORITHM(1)) u_yx (
    .clk_i(clk), .rst_n_i(rst_n), .head_valid_i(head_valid), .target_x_i(tx), .target_y_i(ty),
    .route_ready_o(rdy_o[1]), .out_free_i(out_free), .flit_fire_i(fire), .tail_i(tail),
    .selector_o(sel_o[1]), .route_valid_o(vld_o[1]), .route_error_o(err_o[1]));

  route_selector_adaptive #(.ROUTER_X(1), .ROUTER_Y(1), .ALGORITHM(2)) u_wf (
    .clk_i(clk), .rst_n_i(rst_n), .head_valid_i(head_valid), .target_x_i(tx), .target_y_i(ty),
    .route_ready_o(rdy_o[2]), .out_free_i(out_free), .flit_fire_i(fire), .tail_i(tail),
    .selector_o(sel_o[2]), .route_valid_o(vld_o[2]), .route_error_o(err_o[2]));

  route_selector_adaptive #(.MAX_ROUTERS_X(3), .ROUTER_X(0), .ROUTER_Y(0), .ALGORITHM(0)) u_sm (
    .clk_i(clk), .rst_n_i(rst_n), .head_valid_i(head_valid), .target_x_i(tx), .target_y_i(ty),
    .route_ready_o(rdy_o[3]), .out_free_i(out_free), .flit_fire_i(fire), .tail_i(tail),
    .selector_o(sel_o[3]), .route_valid_o(vld_o[3]), .route_error_o(err_o[3]));

  typedef struct {
    string      name;
    int         dut;
    logic [4:0] sel;
    logic       vld;
    logic       rdy;
  } exp_t;

  typedef struct {
    string      name;
    int         dut;
    logic [1:0] x;
    logic [1:0] y;
    logic [4:0] free;
    logic [4:0] sel;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input string name, input int dut, input logic [4:0] sel,
                      input logic vld, input logic rdy);
    exp_t e;
    e.name = name; e.dut = dut; e.sel = sel; e.vld = vld; e.rdy = rdy;
    sb.push_back(e);
  endtask

  // Compare every pending expectation against the addressed instance's current outputs.
  task automatic check();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      n_checks++;
      if ({sel_o[e.dut], vld_o[e.dut], rdy_o[e.dut]} === {e.sel, e.vld, e.rdy}) n_pass++;
      else $display("FAIL %s: sel/valid/ready got %b/%b/%b want %b/%b/%b", e.name,
                    sel_o[e.dut], vld_o[e.dut], rdy_o[e.dut], e.sel, e.vld, e.rdy);
    end
  endtask

  task automatic check_bit(input string name, input logic got, input logic want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %b want %b", name, got, want);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    head_valid = 1'b0; fire = 1'b0; tail = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic send_head(input logic [1:0] x, input logic [1:0] y, input logic [4:0] free);
    head_valid = 1'b1; tx = x; ty = y; out_free = free;
    tick();
    head_valid = 1'b0;
  endtask

  task automatic release_tail(input string name, input int dut);
    fire = 1'b1; tail = 1'b1;
    tick();
    fire = 1'b0; tail = 1'b0;
    push(name, dut, 5'b00000, 1'b0, 1'b1);
    check();
  endtask

  initial begin
    rst_n = 1'b0; head_valid = 1'b0; tx = '0; ty = '0; out_free = '1; fire = 1'b0; tail = 1'b0;
    vecs[0] = '{"xy_east",      0, 2'd3, 2'd0, 5'b11111, 5'b00100};
    vecs[1] = '{"yx_north",     1, 2'd3, 2'd0, 5'b11111, 5'b00010};
    vecs[2] = '{"yx_local",     1, 2'd1, 2'd1, 5'b11111, 5'b00001};
    vecs[3] = '{"xy_west",      0, 2'd0, 2'd2, 5'b11111, 5'b10000};
    vecs[4] = '{"xy_south",     0, 2'd1, 2'd3, 5'b11111, 5'b01000};
    vecs[5] = '{"wf_south_bsy", 2, 2'd3, 2'd3, 5'b11011, 5'b01000};
    vecs[6] = '{"wf_west",      2, 2'd0, 2'd0, 5'b11111, 5'b10000};
    vecs[7] = '{"wf_north",     2, 2'd1, 2'd0, 5'b11111, 5'b00010};
    vecs[8] = '{"yx_south",     1, 2'd2, 2'd3, 5'b11111, 5'b01000};
    vecs[9] = '{"wf_east",      2, 2'd3, 2'd1, 5'b11111, 5'b00100};

    tick();
    tick();
    push("reset_state", 0, 5'b00000, 1'b0, 1'b1);
    check();
    check_bit("reset_err", err_o[0], 1'b0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 10; i++) begin
      do_reset();
      send_head(vecs[i].x, vecs[i].y, vecs[i].free);
      push(vecs[i].name, vecs[i].dut, vecs[i].sel, 1'b1, 1'b0);
      check();
      release_tail({vecs[i].name, "_rel"}, vecs[i].dut);
    end

    // Multi-flit packet: non-tail fires hold the lock, tail releases it.
    do_reset();
    send_head(2'd3, 2'd0, 5'b11111);
    push("mf_lock", 0, 5'b00100, 1'b1, 1'b0);
    check();
    for (int i = 0; i < 3; i++) begin
      fire = 1'b1; tail = 1'b0; out_free = 5'b00000;
      tick();
      push("mf_hold", 0, 5'b00100, 1'b1, 1'b0);
      check();
    end
    fire = 1'b0;
    release_tail("mf_rel", 0);
    send_head(2'd3, 2'd0, 5'b11111);
    push("mf_next_head", 0, 5'b00100, 1'b1, 1'b0);
    check();

    // Adaptive tie-break: a non-tie grant leaves rr alone, ties alternate.
    do_reset();
    send_head(2'd3, 2'd3, 5'b11011);
    push("rr_south_notie", 2, 5'b01000, 1'b1, 1'b0);
    check();
    release_tail("rr_rel0", 2);
    send_head(2'd3, 2'd3, 5'b11111);
    push("rr_tie_east", 2, 5'b00100, 1'b1, 1'b0);
    check();
    release_tail("rr_rel1", 2);
    send_head(2'd3, 2'd3, 5'b11111);
    push("rr_tie_south", 2, 5'b01000, 1'b1, 1'b0);
    check();
    release_tail("rr_rel2", 2);

    // West-first WAIT: west busy, no fallback to the free south port.
    do_reset();
    send_head(2'd0, 2'd3, 5'b01111);
    for (int i = 0; i < 4; i++) begin
      push("wait_hold", 2, 5'b00000, 1'b0, 1'b0);
      check();
      tick();
    end
    out_free = 5'b11111;
    tick();
    push("wait_lock_west", 2, 5'b10000, 1'b1, 1'b0);
    check();

    // Out-of-range target on the 3-column mesh.
    do_reset();
    send_head(2'd3, 2'd0, 5'b11111);
    check_bit("err_pulse", err_o[3], 1'b1);
    push("err_no_lock", 3, 5'b00000, 1'b0, 1'b1);
    check();
    tick();
    check_bit("err_one_cycle", err_o[3], 1'b0);
    send_head(2'd2, 2'd0, 5'b11111);
    push("small_in_range", 3, 5'b00100, 1'b1, 1'b0);
    check();
    check_bit("small_no_err", err_o[3], 1'b0);

    // Asynchronous reset mid-lock, then rr restarts at 0.
    do_reset();
    send_head(2'd3, 2'd3, 5'b11111);
    push("rst_pre_lock", 2, 5'b00100, 1'b1, 1'b0);
    check();
    #2 rst_n = 1'b0;
    #1;
    push("rst_async_drop", 2, 5'b00000, 1'b0, 1'b1);
    check();
    tick();
    rst_n = 1'b1;
    tick();
    send_head(2'd3, 2'd3, 5'b11111);
    push("rst_rr_zero", 2, 5'b00100, 1'b1, 1'b0);
    check();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
